i2s_mic_emulator: RTL and testbench



---
 rtl/i2s_mic_emulator_if.sv | 20 ++
 rtl/i2s_mic_emulator.sv | 122 ++++++++++++
 tb/tb_i2s_mic_emulator.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_mic_emulator_if.sv
// Parallel sample handshake into the I2S mic emulator (producer = master, emulator = slave).
interface i2s_mic_emulator_if #(
  parameter int SAMPLE_BITS = 16
) ();
  logic [SAMPLE_BITS-1:0] sample_in;
  logic                   sample_valid_in;
  logic                   sample_ready_out;

  modport master (
    output sample_in,
    output sample_valid_in,
    input  sample_ready_out
  );

  modport slave (
    input  sample_in,
    input  sample_valid_in,
    output sample_ready_out
  );
endinterface

// File: rtl/i2s_mic_emulator.sv
// I2S MEMS mic model (left slot, SEL low); I2S_MIC_EMU_DITHER_EN fills pad bits from an LFSR.
// Outputs change 2 audio_clk cycles after a raw BCLK/LRCL pin edge; one-deep sample holding register,
// sample_ready_out low while it is full, emptied at each frame start.
module i2s_mic_emulator #(
  parameter int SAMPLE_BITS = 16,
  parameter int WORD_BITS   = 24,
  parameter int SLOT_BITS   = 32
) (
  input  logic              audio_clk,
  input  logic              rst_in,
  input  logic              i2s_clk,
  input  logic              lrcl_clk,
  i2s_mic_emulator_if.slave smp,
  output logic              mic_data,
  output logic              mic_data_oe,
  output logic              underflow_out
);
  localparam int PAD_BITS = WORD_BITS - SAMPLE_BITS;
  localparam int CNT_W    = $clog2(SLOT_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(WORD_BITS);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    SHIFT
  } state_t;

  state_t                 state;
  logic                   bclk_r1, bclk_r2;
  logic                   lr_r1, lr_r2;
  logic                   bclk_fall, lr_fall;
  logic [CNT_W-1:0]       cnt;
  logic [WORD_BITS-1:0]   shift_q;
  logic [SAMPLE_BITS-1:0] hold_q;
  logic                   hold_full;
  logic [SAMPLE_BITS-1:0] last_q;
  logic [PAD_BITS-1:0]    pad_bits;
  logic                   take;

  assign bclk_fall            = bclk_r2 & ~bclk_r1;
  assign lr_fall              = lr_r2 & ~lr_r1;
  assign take                 = smp.sample_valid_in & ~hold_full;
  assign smp.sample_ready_out = ~hold_full;

`ifdef I2S_MIC_EMU_DITHER_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  // Fibonacci taps 16,14,13,11 in right-shift form; pad uses the value before the step.
  assign lfsr_fb  = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign pad_bits = lfsr[PAD_BITS-1:0];

  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      lfsr <= 16'hACE1;
    end else if (lr_fall) begin
      lfsr <= {lfsr_fb, lfsr[15:1]};
    end
  end
`else
  assign pad_bits = '0;
`endif

  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      bclk_r1       <= 1'b0;
      bclk_r2       <= 1'b0;
      lr_r1         <= 1'b0;
      lr_r2         <= 1'b0;
      state         <= IDLE;
      cnt           <= '0;
      shift_q       <= '0;
      hold_q        <= '0;
      hold_full     <= 1'b0;
      last_q        <= '0;
      mic_data      <= 1'b0;
      mic_data_oe   <= 1'b0;
      underflow_out <= 1'b0;
    end else begin
      bclk_r1       <= i2s_clk;
      bclk_r2       <= bclk_r1;
      lr_r1         <= lrcl_clk;
      lr_r2         <= lr_r1;
      underflow_out <= 1'b0;

      // A word-select fall always restarts the slot, even mid-word.
      if (lr_fall) begin
        state       <= ARM;
        cnt         <= '0;
        mic_data_oe <= 1'b1;
        mic_data    <= 1'b0;
        if (hold_full) begin
          shift_q <= {hold_q, pad_bits};
          last_q  <= hold_q;
        end else begin
          shift_q       <= {last_q, pad_bits};
          underflow_out <= 1'b1;
        end
      end else if (state != IDLE && lr_r1) begin
        state       <= IDLE;
        mic_data_oe <= 1'b0;
        mic_data    <= 1'b0;
      end else if (bclk_fall &&
                   (state == ARM || (state == SHIFT && cnt != LAST_CNT))) begin
        state    <= SHIFT;
        mic_data <= (cnt < WORD_CNT) ? shift_q[WORD_BITS-1] : 1'b0;
        shift_q  <= shift_q << 1;
        cnt      <= cnt + 1'b1;
      end

      // Holding is empty whenever a frame starts and accepts, so ARM always sees the prior contents.
      if (take) begin
        hold_q    <= smp.sample_in;
        hold_full <= 1'b1;
      end else if (lr_fall) begin
        hold_q    <= '0;
        hold_full <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_i2s_mic_emulator.sv
// Directed bench for i2s_mic_emulator: BCLK = audio_clk/32, 64 BCLK per LRCL period.
module tb_i2s_mic_emulator;
  logic audio_clk;
  logic rst_in;
  logic i2s_clk;
  logic lrcl_clk;
  logic mic_data;
  logic mic_data_oe;
  logic underflow_out;

  i2s_mic_emulator_if #(.SAMPLE_BITS(16)) smp ();

  i2s_mic_emulator #(
    .SAMPLE_BITS(16),
    .WORD_BITS  (24),
    .SLOT_BITS  (32)
  ) dut (
    .audio_clk    (audio_clk),
    .rst_in       (rst_in),
    .i2s_clk      (i2s_clk),
    .lrcl_clk     (lrcl_clk),
    .smp          (smp.slave),
    .mic_data     (mic_data),
    .mic_data_oe  (mic_data_oe),
    .underflow_out(underflow_out)
  );

  int checks = 0;
  int errors = 0;

  // Generator / capture state (written only by the generator process)
  int          p = 1023;
  bit          gen_en = 1'b0;
  bit          seen_left = 1'b0;
  int          frame_cnt = 0;
  int          right_bad = 0;
  logic [15:0] tb_lfsr = 16'hACE1;
  logic [23:0] cur_word;
  logic [6:0]  cur_tail;
  logic        cur_b0;
  int          cur_oe;
  int          cur_uf;
  logic [7:0]  cur_pad;
  logic [23:0] rec_word[64];
  logic [6:0]  rec_tail[64];
  logic        rec_b0[64];
  int          rec_oe[64];
  int          rec_uf[64];
  logic [7:0]  rec_pad[64];

  initial begin
    audio_clk = 1'b0;
    forever #5 audio_clk = ~audio_clk;
  end

  initial begin
    int b;
    forever begin
      @(posedge audio_clk);
      if (rst_in === 1'b1) tb_lfsr = 16'hACE1;
      @(negedge audio_clk);
      if (gen_en) begin
        p        = (p + 1) % 2048;
        b        = p / 32;
        i2s_clk  = ((p % 32) >= 16);
        lrcl_clk = (b >= 32);
        if (p == 0) begin
          seen_left = 1'b1;
          cur_word  = '0;
          cur_tail  = '0;
          cur_b0    = 1'b0;
          cur_oe    = 0;
          cur_uf    = 0;
`ifdef I2S_MIC_EMU_DITHER_EN
          cur_pad   = tb_lfsr[7:0];
          tb_lfsr   = {tb_lfsr[0] ^ tb_lfsr[2] ^ tb_lfsr[3] ^ tb_lfsr[5], tb_lfsr[15:1]};
`else
          cur_pad   = 8'h00;
`endif
        end
        if (underflow_out === 1'b1 && p < 1056) cur_uf++;
        if ((p % 32) == 16) begin
          if (b < 32) begin
            if (mic_data_oe === 1'b1) cur_oe++;
            if (b == 0) cur_b0 = mic_data;
            else if (b <= 24) cur_word = {cur_word[22:0], mic_data};
            else cur_tail = {cur_tail[5:0], mic_data};
          end else if (mic_data_oe !== 1'b0 || mic_data !== 1'b0) begin
            right_bad++;
          end
        end
        if (p == 1056 && seen_left) begin
          rec_word[frame_cnt] = cur_word;
          rec_tail[frame_cnt] = cur_tail;
          rec_b0[frame_cnt]   = cur_b0;
          rec_oe[frame_cnt]   = cur_oe;
          rec_uf[frame_cnt]   = cur_uf;
          rec_pad[frame_cnt]  = cur_pad;
          frame_cnt++;
        end
      end
    end
  end

  task automatic wait_frame(input int n, output int idx);
    int guard = 0;
    while (frame_cnt < n && guard < 6000) begin
      @(negedge audio_clk);
      guard++;
    end
    if (frame_cnt < n) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout got %0d frames want %0d", frame_cnt, n);
    end
    idx = n - 1;
  endtask

  task automatic send(input logic [15:0] d, output int acc_p);
    int guard = 0;
    smp.sample_in       = d;
    smp.sample_valid_in = 1'b1;
    while (smp.sample_ready_out !== 1'b1 && guard < 4000) begin
      @(negedge audio_clk);
      guard++;
    end
    if (smp.sample_ready_out !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout data %h ready stuck at %b", d, smp.sample_ready_out);
    end
    acc_p = p;
    @(negedge audio_clk);
    smp.sample_valid_in = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_in = 1'b1;
    @(negedge audio_clk);
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (4) @(negedge audio_clk);
    rst_in = 1'b0;
    @(negedge audio_clk);
    checks++; if (mic_data !== 1'b0) begin errors++; $display("FAIL reset_mic_data got %b want 0", mic_data); end
    checks++; if (mic_data_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", mic_data_oe); end
    checks++; if (underflow_out !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b want 0", underflow_out); end
    checks++; if (smp.sample_ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", smp.sample_ready_out); end
  endtask

  task automatic test_basic(inout int fr);
    int ap, k;
    send(16'hA5C3, ap);
    checks++; if (smp.sample_ready_out !== 1'b0) begin errors++; $display("FAIL basic_ready_drop got %b want 0", smp.sample_ready_out); end
    gen_en = 1'b1;
    fr++;
    wait_frame(fr, k);
    checks++; if (rec_word[k] !== {16'hA5C3, rec_pad[k]}) begin errors++; $display("FAIL basic_word got %h want %h", rec_word[k], {16'hA5C3, rec_pad[k]}); end
    checks++; if (rec_tail[k] !== 7'd0) begin errors++; $display("FAIL basic_tail got %h want 0", rec_tail[k]); end
    checks++; if (rec_b0[k] !== 1'b0) begin errors++; $display("FAIL basic_delay_bit got %b want 0", rec_b0[k]); end
    checks++; if (rec_oe[k] != 32) begin errors++; $display("FAIL basic_oe_count got %0d want 32", rec_oe[k]); end
    checks++; if (rec_uf[k] != 0) begin errors++; $display("FAIL basic_underflow got %0d want 0", rec_uf[k]); end
    checks++; if (smp.sample_ready_out !== 1'b1) begin errors++; $display("FAIL basic_ready_back got %b want 1", smp.sample_ready_out); end
  endtask

  task automatic test_underflow(inout int fr);
    int ap, k;
    pulse_reset();
    fr++;
    wait_frame(fr, k);
    checks++; if (rec_word[k] !== {16'h0000, rec_pad[k]}) begin errors++; $display("FAIL uf0_word got %h want %h", rec_word[k], {16'h0000, rec_pad[k]}); end
    checks++; if (rec_uf[k] != 1) begin errors++; $display("FAIL uf0_pulses got %0d want 1", rec_uf[k]); end
    send(16'h8001, ap);
    fr++;
    wait_frame(fr, k);
    checks++; if (rec_word[k] !== {16'h8001, rec_pad[k]}) begin errors++; $display("FAIL uf1_word got %h want %h", rec_word[k], {16'h8001, rec_pad[k]}); end
    checks++; if (rec_uf[k] != 0) begin errors++; $display("FAIL uf1_pulses got %0d want 0", rec_uf[k]); end
    fr++;
    wait_frame(fr, k);
    checks++; if (rec_word[k] !== {16'h8001, rec_pad[k]}) begin errors++; $display("FAIL uf2_word got %h want %h", rec_word[k], {16'h8001, rec_pad[k]}); end
    checks++; if (rec_uf[k] != 1) begin errors++; $display("FAIL uf2_pulses got %0d want 1", rec_uf[k]); end
  endtask

  task automatic test_back_to_back(inout int fr);
    int ap, k;
    send(16'h1111, ap);
    checks++; if (smp.sample_ready_out !== 1'b0) begin errors++; $display("FAIL b2b_ready_low got %b want 0", smp.sample_ready_out); end
    send(16'h2222, ap);
    checks++; if (ap < 1 || ap > 3) begin errors++; $display("FAIL b2b_accept_phase got %0d want 1..3", ap); end
    fr++;
    wait_frame(fr, k);
    checks++; if (rec_word[k] !== {16'h1111, rec_pad[k]}) begin errors++; $display("FAIL b2b_first_word got %h want %h", rec_word[k], {16'h1111, rec_pad[k]}); end
    checks++; if (rec_uf[k] != 0) begin errors++; $display("FAIL b2b_first_uf got %0d want 0", rec_uf[k]); end
    fr++;
    wait_frame(fr, k);
    checks++; if (rec_word[k] !== {16'h2222, rec_pad[k]}) begin errors++; $display("FAIL b2b_second_word got %h want %h", rec_word[k], {16'h2222, rec_pad[k]}); end
    checks++; if (rec_uf[k] != 0) begin errors++; $display("FAIL b2b_second_uf got %0d want 0", rec_uf[k]); end
  endtask

  task automatic test_right_slot(inout int fr);
    int ap, k, rb0;
    send(16'hFFFF, ap);
    rb0 = right_bad;
    fr++;
    wait_frame(fr, k);
    checks++; if (rec_word[k] !== {16'hFFFF, rec_pad[k]}) begin errors++; $display("FAIL right_left_word got %h want %h", rec_word[k], {16'hFFFF, rec_pad[k]}); end
    fr++;
    wait_frame(fr, k);
    checks++; if (rec_uf[k] != 1) begin errors++; $display("FAIL right_repeat_uf got %0d want 1", rec_uf[k]); end
    checks++; if (right_bad != rb0) begin errors++; $display("FAIL right_slot_driven got %0d bad bits want 0", right_bad - rb0); end
  endtask

  task automatic test_reset_mid(inout int fr);
    int ap, k;
    int guard = 0;
    send(16'hFFFF, ap);
    while (!(p == 340 && frame_cnt == fr) && guard < 4000) begin
      @(negedge audio_clk);
      guard++;
    end
    if (guard >= 4000) begin
      checks++; errors++;
      $display("FAIL midrst_sync_timeout phase %0d", p);
    end
    pulse_reset();
    checks++; if (mic_data !== 1'b0) begin errors++; $display("FAIL midrst_mic_data got %b want 0", mic_data); end
    checks++; if (mic_data_oe !== 1'b0) begin errors++; $display("FAIL midrst_oe got %b want 0", mic_data_oe); end
    checks++; if (smp.sample_ready_out !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", smp.sample_ready_out); end
    fr++;
    wait_frame(fr, k);
    checks++; if (rec_word[k] !== 24'hFFC000) begin errors++; $display("FAIL midrst_trunc_word got %h want ffc000", rec_word[k]); end
    checks++; if (rec_oe[k] != 11) begin errors++; $display("FAIL midrst_oe_count got %0d want 11", rec_oe[k]); end
    checks++; if (rec_tail[k] !== 7'd0) begin errors++; $display("FAIL midrst_tail got %h want 0", rec_tail[k]); end
    fr++;
    wait_frame(fr, k);
    checks++; if (rec_word[k] !== {16'h0000, rec_pad[k]}) begin errors++; $display("FAIL midrst_next_word got %h want %h", rec_word[k], {16'h0000, rec_pad[k]}); end
    checks++; if (rec_uf[k] != 1) begin errors++; $display("FAIL midrst_next_uf got %0d want 1", rec_uf[k]); end
`ifdef I2S_MIC_EMU_DITHER_EN
    checks++; if (rec_word[k][7:0] !== 8'hE1) begin errors++; $display("FAIL dither_first_pad got %h want e1", rec_word[k][7:0]); end
`else
    checks++; if (rec_word[k][7:0] !== 8'h00) begin errors++; $display("FAIL nodither_pad got %h want 00", rec_word[k][7:0]); end
`endif
  endtask

  initial begin
    int fr;
    fr                  = 0;
    rst_in              = 1'b1;
    i2s_clk             = 1'b0;
    lrcl_clk            = 1'b1;
    smp.sample_in       = '0;
    smp.sample_valid_in = 1'b0;
    @(negedge audio_clk);
    test_reset();
    test_basic(fr);
    test_underflow(fr);
    test_back_to_back(fr);
    test_right_slot(fr);
    test_reset_mid(fr);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
